ex_mem_stage: RTL

Execute-stage back end and EX/MEM pipeline register of the RISC-V pipeline. It consumes the ALU result and zero flag together with the ID/EX control bundle and resolves branches and jumps into a PC redirect plus a flush of younger instructions. It also forms the link value, checks alignment, builds store data and byte enables, and registers everything into the MEM stage with stall and flush support.

---
 rtl/ex_mem_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX back end: branch/jump resolution, link value, alignment checks, store formatting, EX/MEM register.
// Latency: redirect/flush combinational, mem_* 1 cycle. Backpressure: stall holds mem_* and gates redirect.
module ex_mem_stage #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs2_data,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_memwrite,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_branch,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    input  logic             stall,
    input  logic             flush_i,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic             mem_valid,
    output logic             mem_regwrite,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_exc,
    output logic [XLEN-1:0]  mem_pc,
    output logic [XLEN-1:0]  mem_result,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [REG_W-1:0] mem_rd,
    output logic [2:0]       mem_funct3,
    output logic [3:0]       mem_be
);

    logic            live;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            tmis;
    logic            dmis;
    logic            exc;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic [1:0]      addr_lo;

    assign live    = ex_valid & ~flush_i;
    assign taken   = live & (ex_jal | ex_jalr | (ex_branch & ~alu_zero));
    assign target  = ex_jalr ? alu_result : ex_pc + ex_imm;
    assign tmis    = taken & target[1];
    assign addr_lo = alu_result[1:0];

    // A misaligned jump target traps instead of redirecting.
    assign redirect_o    = taken & ~tmis & ~stall & rst_n;
    assign redirect_pc_o = target;
    assign flush_o       = redirect_o;

    always_comb begin
        dmis = 1'b0;
        if (ex_memread | ex_memwrite) begin
            if (ex_funct3[1:0] == 2'b01 && addr_lo[0])
                dmis = 1'b1;
            if (ex_funct3[1:0] == 2'b10 && addr_lo != 2'b00)
                dmis = 1'b1;
            if (ex_memwrite && ex_funct3 > 3'b010)
                dmis = 1'b1;
        end
    end

    assign exc    = live & (tmis | dmis);
    assign result = (ex_jal | ex_jalr) ? ex_pc + XLEN'(4) : alu_result;

    always_comb begin
        case (ex_funct3[1:0])
            2'b00:   wdata = {4{ex_rs2_data[7:0]}};
            2'b01:   wdata = {2{ex_rs2_data[15:0]}};
            default: wdata = ex_rs2_data;
        endcase
    end

    always_comb begin
        be = 4'b0000;
        if (ex_memwrite && !exc) begin
            case (ex_funct3)
                3'b000:  be = 4'b0001 << addr_lo;
                3'b001:  be = 4'b0011 << {addr_lo[1], 1'b0};
                3'b010:  be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i || (!stall && !ex_valid)) begin
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_exc      <= 1'b0;
            mem_pc       <= '0;
            mem_result   <= '0;
            mem_wdata    <= '0;
            mem_rd       <= '0;
            mem_funct3   <= '0;
            mem_be       <= '0;
        end else if (!stall) begin
            mem_valid    <= live;
            mem_regwrite <= ex_regwrite & live & ~exc;
            mem_memread  <= ex_memread  & live & ~exc;
            mem_memwrite <= ex_memwrite & live & ~exc;
            mem_exc      <= exc;
            mem_pc       <= ex_pc;
            mem_result   <= result;
            mem_wdata    <= wdata;
            mem_rd       <= ex_rd;
            mem_funct3   <= ex_funct3;
            mem_be       <= be;
        end
    end

endmodule
